// File: rtl/eth_tx_arb.sv
// Packet-granular round-robin arbiter in front of eth_tx: grants one byte-stream
// source per packet, forwards its bytes with one registered stage, then waits out TX and IFG.
module eth_tx_arb #(
  parameter int pNum_Req       = 3,
  parameter int pIfg_Cycles    = 48,
  parameter int pStart_Timeout = 64,
  parameter int pTxen_Wait     = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [pNum_Req-1:0]    Req,
  output logic [pNum_Req-1:0]    Gnt,
  input  logic [10*pNum_Req-1:0] Eth_Byte_In,
  input  logic [pNum_Req-1:0]    Eth_Byte_Valid_In,
  input  logic                   Tx_En,
  output logic [9:0]             Eth_Byte_Out,
  output logic                   Eth_Byte_Valid_Out,
  output logic [2:0]             Gnt_Idx,
  output logic                   Busy,
  output logic                   Err_Timeout,
  output logic                   Err_Gap,
  output logic [15:0]            Pkt_Cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_XFER,
    S_DRAIN,
    S_IFG
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [2:0]          gnt_idx_q, gnt_idx_d;
  logic [pNum_Req-1:0] gnt_q, gnt_d;
  logic [9:0]          byte_q, byte_d;
  logic                valid_q, valid_d;
  logic                err_tmo_q, err_tmo_d;
  logic                err_gap_q, err_gap_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                seen_q, seen_d;

  logic [9:0]          sel_byte;
  logic                sel_valid;
  logic                sel_req;
  logic                hi_found, lo_found, win_found;
  logic [2:0]          hi_idx, lo_idx, win_idx;
  logic [pNum_Req-1:0] win_onehot;

  always_comb begin
    sel_byte  = '0;
    sel_valid = 1'b0;
    sel_req   = 1'b0;
    for (int unsigned i = 0; i < pNum_Req; i++) begin
      if (gnt_idx_q == 3'(i)) begin
        sel_byte  = Eth_Byte_In[10*i +: 10];
        sel_valid = Eth_Byte_Valid_In[i];
        sel_req   = Req[i];
      end
    end
  end

  // Two priority searches replace the modulo walk: lowest request at/above
  // the pointer, else the lowest request overall (the wrapped case).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = pNum_Req - 1; j >= 0; j--) begin
      if (Req[j]) begin
        if (3'(j) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = 3'(j);
        end
        lo_found = 1'b1;
        lo_idx   = 3'(j);
      end
    end
    win_found = hi_found | lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
    for (int unsigned i = 0; i < pNum_Req; i++) begin
      win_onehot[i] = (win_idx == 3'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_d     = gnt_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_tmo_d = 1'b0;
    err_gap_d = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    cnt_d     = cnt_q;
    seen_d    = seen_q;
    case (state_q)
      S_IDLE: begin
        if (win_found && !Tx_En) begin
          state_d   = S_GRANT;
          gnt_idx_d = win_idx;
          gnt_d     = win_onehot;
          ptr_d     = (win_idx == 3'(pNum_Req - 1)) ? 3'd0 : win_idx + 3'd1;
          cnt_d     = '0;
        end
      end
      S_GRANT: begin
        if (sel_valid && sel_byte[9]) begin
          byte_d  = sel_byte;
          valid_d = 1'b1;
          if (sel_byte[8]) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            gnt_d     = '0;
            state_d   = S_DRAIN;
            cnt_d     = '0;
            seen_d    = 1'b0;
          end else begin
            state_d = S_XFER;
          end
        end else if (!sel_req) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q + 16'd1 == 16'(pStart_Timeout)) begin
          err_tmo_d = 1'b1;
          gnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_XFER: begin
        gnt_d = gnt_q;
        if (sel_valid) begin
          byte_d  = sel_byte;
          valid_d = 1'b1;
          if (sel_byte[8]) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            gnt_d     = '0;
            state_d   = S_DRAIN;
            cnt_d     = '0;
            seen_d    = 1'b0;
          end
        end else begin
          err_gap_d = 1'b1;
          gnt_d     = '0;
          state_d   = S_DRAIN;
          cnt_d     = '0;
          seen_d    = 1'b0;
        end
      end
      S_DRAIN: begin
        if (!seen_q) begin
          if (Tx_En) begin
            seen_d = 1'b1;
          end else if (cnt_q == 16'(pTxen_Wait)) begin
            state_d = S_IFG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else if (!Tx_En) begin
          state_d = S_IFG;
          cnt_d   = '0;
        end
      end
      S_IFG: begin
        if (Tx_En) begin
          cnt_d = '0;
        end else if (cnt_q + 16'd1 == 16'(pIfg_Cycles)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_q     <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_tmo_q <= 1'b0;
      err_gap_q <= 1'b0;
      pkt_cnt_q <= '0;
      cnt_q     <= '0;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_q     <= gnt_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      err_tmo_q <= err_tmo_d;
      err_gap_q <= err_gap_d;
      pkt_cnt_q <= pkt_cnt_d;
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
    end
  end

  assign Gnt                = gnt_q;
  assign Eth_Byte_Out       = byte_q;
  assign Eth_Byte_Valid_Out = valid_q;
  assign Gnt_Idx            = gnt_idx_q;
  assign Busy               = (state_q != S_IDLE);
  assign Err_Timeout        = err_tmo_q;
  assign Err_Gap            = err_gap_q;
  assign Pkt_Cnt            = pkt_cnt_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Bench for eth_tx_arb: directed vector table, hand-written corner sequences, and
// randomized packets checked against a transaction-level round-robin model.
module tb_eth_tx_arb;
  localparam int N   = 3;
  localparam int IFG = 48;
  localparam int TMO = 64;
  localparam int TXW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [10*N-1:0] byte_in;
  logic [N-1:0]    vin;
  logic            tx_en;
  logic [N-1:0]    gnt;
  logic [9:0]      bout;
  logic            vout;
  logic [2:0]      gidx;
  logic            busy, etmo, egap;
  logic [15:0]     pcnt;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          cyc   = 0;

  always #5 clk = ~clk;

  eth_tx_arb #(
    .pNum_Req      (N),
    .pIfg_Cycles   (IFG),
    .pStart_Timeout(TMO),
    .pTxen_Wait    (TXW)
  ) dut (
    .Clk               (clk),
    .Rst               (rst),
    .Req               (req),
    .Gnt               (gnt),
    .Eth_Byte_In       (byte_in),
    .Eth_Byte_Valid_In (vin),
    .Tx_En             (tx_en),
    .Eth_Byte_Out      (bout),
    .Eth_Byte_Valid_Out(vout),
    .Gnt_Idx           (gidx),
    .Busy              (busy),
    .Err_Timeout       (etmo),
    .Err_Gap           (egap),
    .Pkt_Cnt           (pcnt)
  );

  typedef struct {
    logic [N-1:0] req;
    int           src;
    logic [9:0]   b;
    logic         v;
    logic         txen;
    logic [N-1:0] e_gnt;
    logic         e_v;
    logic [9:0]   e_b;
    logic [15:0]  e_pkt;
    logic         e_busy;
  } vec_t;

  vec_t tbl[10];

  int         remaining[N];
  int         active, dly, ptr_m, w, len, n;
  int         pkts_total, pkts_out, tx_start, tx_len, txen_fall, lim;
  logic [N-1:0] gnt_prev;
  logic       tx_prev;
  logic [9:0] cur[$];
  logic [9:0] expq[$];
  logic [9:0] b, e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_src(input int s, input logic [9:0] v_b, input logic v_v);
    byte_in[10*s +: 10] = v_b;
    vin[s]              = v_v;
  endtask

  task automatic junk_except(input int s);
    for (int i = 0; i < N; i++) begin
      if (i != s) set_src(i, 10'($urandom), 1'($urandom));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"},   gnt,  0);
    check({tag, " vout"},  vout, 0);
    check({tag, " bout"},  bout, 0);
    check({tag, " gidx"},  gidx, 0);
    check({tag, " busy"},  busy, 0);
    check({tag, " etmo"},  etmo, 0);
    check({tag, " egap"},  egap, 0);
    check({tag, " pcnt"},  pcnt, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; vin = '0; byte_in = '0; tx_en = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      req   = tbl[k].req;
      tx_en = tbl[k].txen;
      junk_except(tbl[k].src);
      set_src(tbl[k].src, tbl[k].b, tbl[k].v);
      step();
      check($sformatf("vec%0d gnt", k),  gnt,  tbl[k].e_gnt);
      check($sformatf("vec%0d vout", k), vout, tbl[k].e_v);
      if (tbl[k].e_v) check($sformatf("vec%0d bout", k), bout, tbl[k].e_b);
      check($sformatf("vec%0d pcnt", k), pcnt, tbl[k].e_pkt);
      check($sformatf("vec%0d busy", k), busy, tbl[k].e_busy);
    end
  endtask

  // Steps with idle inputs until Busy drops; returns the number of steps taken.
  task automatic wait_idle(input int limit, output int cnt);
    cnt = 0;
    req = '0;
    while (busy && cnt < limit) begin
      junk_except(-1);
      step();
      cnt++;
    end
    check("wait idle bound", busy, 0);
  endtask

  function automatic bit all_done();
    bit d = (active < 0) && (expq.size() == 0);
    for (int i = 0; i < N; i++) if (remaining[i] != 0) d = 0;
    return d;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //              req    src b        v     tx    e_gnt  e_v  e_b      e_pkt  e_busy
    tbl[0] = '{3'b010, 1, 10'h000, 1'b0, 1'b0, 3'b010, 1'b0, 10'h000, 16'd0, 1'b1};
    tbl[1] = '{3'b010, 1, 10'h2AA, 1'b1, 1'b0, 3'b010, 1'b1, 10'h2AA, 16'd0, 1'b1};
    tbl[2] = '{3'b010, 1, 10'h055, 1'b1, 1'b0, 3'b010, 1'b1, 10'h055, 16'd0, 1'b1};
    tbl[3] = '{3'b010, 1, 10'h1C3, 1'b1, 1'b0, 3'b000, 1'b1, 10'h1C3, 16'd1, 1'b1};
    tbl[4] = '{3'b000, 1, 10'h000, 1'b0, 1'b1, 3'b000, 1'b0, 10'h000, 16'd1, 1'b1};
    tbl[5] = '{3'b000, 1, 10'h000, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 16'd1, 1'b1};
    tbl[6] = '{3'b100, 2, 10'h000, 1'b0, 1'b0, 3'b100, 1'b0, 10'h000, 16'd1, 1'b1};
    tbl[7] = '{3'b100, 2, 10'h012, 1'b1, 1'b0, 3'b100, 1'b0, 10'h000, 16'd1, 1'b1};
    tbl[8] = '{3'b100, 2, 10'h3FF, 1'b1, 1'b0, 3'b000, 1'b1, 10'h3FF, 16'd2, 1'b1};
    tbl[9] = '{3'b000, 2, 10'h000, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 16'd2, 1'b1};

    do_reset();

    // Single packet from source 1, then Tx_En pulse and exact IFG length.
    run_vectors(0, 5);
    check("single gidx", gidx, 1);
    wait_idle(200, n);
    check("ifg length", n, IFG);

    // Non-SOP byte dropped, 1-byte packet forwarded (pointer now at 2).
    run_vectors(6, 9);
    check("drop gidx", gidx, 2);
    wait_idle(300, n);

    // Start timeout on source 2.
    req = 3'b100; junk_except(2); set_src(2, 10'h000, 1'b0);
    step();
    check("tmo gnt", gnt, 3'b100);
    n = 0;
    while (!etmo && n < 200) begin
      junk_except(2);
      b = 10'($urandom); b[9] = 1'b0;
      set_src(2, b, 1'($urandom));
      step();
      n++;
    end
    check("tmo latency", n, TMO);
    check("tmo gnt low", gnt, 0);
    check("tmo vout", vout, 0);
    set_src(2, 10'h000, 1'b0);
    step();
    check("tmo regrant no ifg", gnt, 3'b100);
    check("tmo pulse width", etmo, 0);
    req = 3'b000;
    step();
    check("req drop busy", busy, 0);
    check("req drop gnt", gnt, 0);
    check("req drop no err", {etmo, egap}, 0);

    // Gap error on source 0, then DRAIN timeout + IFG with Tx_En low.
    req = 3'b001; junk_except(0); set_src(0, 10'h000, 1'b0);
    step();
    check("gap gnt", gnt, 3'b001);
    junk_except(0); set_src(0, 10'h2AB, 1'b1);
    step();
    check("gap sop out", bout, 10'h2AB);
    junk_except(0); set_src(0, 10'h0CD, 1'b1);
    step();
    check("gap data out", bout, 10'h0CD);
    check("gap data vout", vout, 1);
    junk_except(0); set_src(0, 10'h000, 1'b0);
    step();
    check("gap err pulse", egap, 1);
    check("gap gnt low", gnt, 0);
    check("gap vout", vout, 0);
    check("gap pcnt", pcnt, 2);
    n = 0;
    while (gnt == '0 && n < 200) begin
      junk_except(0);
      step();
      n++;
    end
    check("gap regrant delay", n, TXW + IFG + 2);
    req = 3'b000;
    step();
    check("gap release busy", busy, 0);

    // Reset in the middle of a packet from source 1.
    req = 3'b010; junk_except(1); set_src(1, 10'h000, 1'b0);
    step();
    check("rstmid gnt", gnt, 3'b010);
    junk_except(1); set_src(1, 10'h201, 1'b1);
    step();
    junk_except(1); set_src(1, 10'h002, 1'b1);
    step();
    junk_except(1); set_src(1, 10'h003, 1'b1);
    rst = 1'b1;
    step();
    check_all_zero("rstmid");
    rst = 1'b0;
    req = 3'b110; junk_except(-1);
    step();
    check("rstmid lowest grant", gnt, 3'b010);
    req = 3'b000;
    step();

    // Randomized packets against the round-robin transaction model.
    do_reset();
    pkts_total = 0;
    for (int i = 0; i < N; i++) begin
      remaining[i] = int'($urandom_range(2, 4));
      pkts_total  += remaining[i];
    end
    active = -1; ptr_m = 0; pkts_out = 0; tx_start = -1; tx_len = 0;
    txen_fall = -1000; gnt_prev = '0; tx_prev = 1'b0; dly = 0;
    lim = cyc + 8000;
    for (int i = 0; i < N; i++) req[i] = (remaining[i] > 0);
    junk_except(-1);
    while (cyc < lim && !(all_done() && !busy)) begin
      step();
      check("rnd no err", {etmo, egap}, 0);
      if (gnt != '0 && gnt_prev == '0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (ptr_m + k) % N;
          if (w < 0 && remaining[c] > 0) w = c;
        end
        if (w < 0) begin
          check("rnd spurious gnt", gnt, 0);
        end else begin
          check("rnd rr gnt", gnt, 32'(1) << w);
          check("rnd rr gidx", gidx, w);
          check("rnd ifg spacing", (cyc - txen_fall) >= IFG + 2, 1);
          ptr_m  = (w + 1) % N;
          active = w;
          dly    = int'($urandom_range(0, 8));
          len    = int'($urandom_range(1, 6));
          for (int k = 0; k < len; k++) begin
            b = 10'($urandom);
            if (k == 0) b[9] = 1'b1;
            b[8] = (k == len - 1);
            cur.push_back(b);
            expq.push_back(b);
          end
        end
      end
      gnt_prev = gnt;
      if (vout) begin
        if (expq.size() == 0) begin
          check("rnd spurious byte", vout, 0);
        end else begin
          e = expq.pop_front();
          check("rnd data", bout, e);
          if (e[8]) begin
            pkts_out++;
            check("rnd pkt cnt", pcnt, pkts_out);
            check("rnd gnt at eop", gnt, 0);
            tx_start = cyc + int'($urandom_range(0, 2));
            tx_len   = int'($urandom_range(5, 25));
          end
        end
      end
      for (int i = 0; i < N; i++) req[i] = (remaining[i] > 0);
      junk_except(active);
      if (active >= 0) begin
        if (dly > 0) begin
          b = 10'($urandom); b[9] = 1'b0;
          set_src(active, b, 1'($urandom));
          dly--;
        end else begin
          b = cur.pop_front();
          set_src(active, b, 1'b1);
          if (cur.size() == 0) begin
            remaining[active]--;
            active = -1;
          end
        end
      end
      tx_en = (tx_start >= 0) && (cyc >= tx_start) && (cyc < tx_start + tx_len);
      if (tx_prev && !tx_en) txen_fall = cyc;
      tx_prev = tx_en;
    end
    check("rnd completed in budget", all_done() && !busy, 1);
    check("rnd total pkts", pcnt, pkts_total);
    check("rnd scoreboard empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eth_tx_arb.md
# eth_tx_arb

Packet-granular round-robin arbiter that shares the single `eth_tx` byte interface among `pNum_Req` byte-stream sources, such as RX loopback, the TPG and external user logic. It sits in the `Eth_Clk` domain directly in front of `eth_tx`. It grants one source at a time and forwards that source's packet bytes unchanged. After each packet it holds off the next grant until `eth_tx` has finished transmitting and the inter-frame gap has elapsed.

## Interface
Parameters:
- `pNum_Req`, default 3: number of requesters; legal range 2–8.
- `pIfg_Cycles`, default 48: idle clocks enforced after `Tx_En` falls (96 bit times at 2 bits per clock).
- `pStart_Timeout`, default 64: clocks a granted source may take to present SOP before the grant is revoked.
- `pTxen_Wait`, default 16: clocks to wait for `Tx_En` to rise after EOP before skipping to IFG.

Ports:
- `Clk`  in  1  Eth_Clk.
- `Rst`  in  1  One clock; reset is synchronous and active-high.
- `Req`  in  pNum_Req  per-source request, level.
- `Gnt`  out  pNum_Req  one-hot grant, registered.
- `Eth_Byte_In`  in  10*pNum_Req  flattened bytes; source i occupies `[10i+9:10i]`. Bit 9 = SOP, bit 8 = EOP, bits 7:0 = data.
- `Eth_Byte_Valid_In`  in  pNum_Req  per-source byte valid.
- `Tx_En`  in  1  `Tx_En` from `eth_tx`; 1 means a frame is on the wire.
- `Eth_Byte_Out`  out  10  byte to `eth_tx`.
- `Eth_Byte_Valid_Out`  out  1  valid to `eth_tx`.
- `Gnt_Idx`  out  3  index of the current/last granted source.
- `Busy`  out  1  1 whenever state ≠ IDLE.
- `Err_Timeout`  out  1  one-cycle pulse.
- `Err_Gap`  out  1  one-cycle pulse.
- `Pkt_Cnt`  out  16  packets forwarded; wraps 65535→0.

## Operation
States and transitions:
- **IDLE**: if any `Req` is set and `Tx_En`=0, pick the winner and go to GRANT.
  - Winner is the first set `Req` at or after pointer `Ptr`, searching upward modulo `pNum_Req`.
  - On grant, `Ptr` ← winner+1 mod `pNum_Req` and `Gnt_Idx` ← winner.
- **GRANT**: `Gnt[Gnt_Idx]`=1; wait for the granted source's first byte.
  - Valid byte with SOP: forward it. If EOP is also set (1-byte packet), go to DRAIN; otherwise go to XFER.
  - Valid byte without SOP: drop it.
  - `Req[Gnt_Idx]` falls: go to IDLE with no error and no IFG.
  - `pStart_Timeout` cycles elapse with no SOP: pulse `Err_Timeout`, go to IDLE.
- **XFER**: forward each valid byte from the granted source.
  - Valid with EOP: forward, increment `Pkt_Cnt`, go to DRAIN.
  - SOP seen mid-packet: forward unchanged; it is not an error.
  - Valid=0 before EOP (gap violation): pulse `Err_Gap`, forward nothing, go to DRAIN. `eth_tx` handles the truncated packet.
- **DRAIN**: `Gnt`=0.
  - Wait for `Tx_En`=1, then for `Tx_En`=0, then go to IFG.
  - If `Tx_En` has not risen within `pTxen_Wait` cycles of entering DRAIN, go to IFG directly.
- **IFG**: count `pIfg_Cycles` clocks with `Tx_En`=0, then go to IDLE.
  - If `Tx_En` returns to 1 during IFG, restart the count.

Other rules:
- Bytes and valids from non-granted sources are ignored at all times.
- `Gnt` bits for non-granted sources are always 0.
- `Eth_Byte_Out` bits are never modified; this block has no checksum or header insertion.
- Reset value of every output is 0: `Gnt`, `Eth_Byte_Out`, `Eth_Byte_Valid_Out`, `Gnt_Idx`, `Busy`, `Err_*`, `Pkt_Cnt`. State = IDLE, `Ptr` = 0.
- Reset asserted mid-packet: at the next edge, state = IDLE and `Eth_Byte_Valid_Out` = 0. No flush and no error pulse.

## Timing
- `Gnt` rises 1 clock after the IDLE cycle that sees `Req`=1 with `Tx_En`=0.
- Datapath latency is exactly 1 clock, input edge to output, with a registered mux:
  - Consecutive input bytes produce consecutive output bytes.
  - `Eth_Byte_Valid_Out`=0 on every cycle not carrying a forwarded byte.
- `Gnt` falls on the edge that registers the EOP byte into `Eth_Byte_Out`. The source may drop `Req` on that cycle or later.
- `Err_Timeout` pulses on the edge at which the GRANT cycle count reaches `pStart_Timeout`.
- `Err_Gap` pulses on the edge following the first invalid XFER cycle.
- Minimum spacing between the EOP output and the next `Gnt` is `pIfg_Cycles` + 2 clocks, plus the time `Tx_En` spends high.
- `Pkt_Cnt` updates on the same edge as the EOP output.

## Test plan
- **Single packet**: `Req`=3'b010; source 1 sends SOP `0x2AA`, `0x055`, EOP `0x1C3` on 3 consecutive cycles.
  - Expect `Gnt`=3'b010.
  - Output is the identical 3 bytes, 1 clock later, contiguous.
  - `Pkt_Cnt`=1 and `Gnt_Idx`=1.
- **Round-robin**: all three `Req` held high; each source sends 4-byte packets; model `Tx_En` high for 20 cycles after each EOP.
  - Expect grant order 0, 1, 2, 0.
  - Each grant comes ≥ 48+2 clocks after `Tx_En` falls.
- **Start timeout**: grant source 2, which never sends SOP.
  - Expect `Err_Timeout` pulse exactly 64 cycles after `Gnt` rises.
  - `Gnt` returns to 0; the next request is served without IFG.
- **Gap error**: source 0 sends SOP, then one data byte, then valid=0.
  - Expect `Err_Gap` pulse, `Gnt` low, `Pkt_Cnt` unchanged.
  - The block enters DRAIN/IFG; with `Tx_En` kept 0, the next grant comes 16+48+2 clocks later.
- **Non-SOP drop and 1-byte packet**: granted source first sends `0x012` with no SOP, then `0x3FF` (SOP+EOP).
  - Expect only `0x3FF` on the output; `Pkt_Cnt` increments.
- **Reset mid-packet**: assert `Rst` during the 3rd byte of XFER.
  - Next cycle: all outputs 0, state IDLE.
  - After reset, the first grant goes to the lowest-index requester.
